// File: rtl/bram_sd_ctrl.sv
// Backup-RAM controller: dual-bank byte RAM for the core, sector moves to/from
// the SD save image via the hps_io sd_* handshake (load, save, autosave, format).
module bram_sd_ctrl #(
  parameter int          SECTORS = 16,
  parameter int          AW      = $clog2(SECTORS*512),
  parameter logic [63:0] FMT_HDR = 64'h8010_8800_4D42_5548
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_din,
  input  logic          core_we,
  output logic [7:0]    core_dout,
  input  logic          downloading,
  input  logic          img_mounted,
  input  logic          img_readonly,
  input  logic          img_size_nz,
  input  logic          osd_status,
  input  logic          load_req,
  input  logic          save_req,
  input  logic          format_req,
  input  logic          autosave_en,
  output logic [31:0]   sd_lba,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [7:0]    sd_buff_addr,
  input  logic [15:0]   sd_buff_dout,
  input  logic          sd_buff_wr,
  output logic [15:0]   sd_buff_din,
  output logic          bk_ena,
  output logic          busy,
  output logic          loading,
  output logic          pending
);
  localparam int WA = AW - 1;
  localparam int NW = SECTORS * 256;
  localparam int SW = (SECTORS > 1) ? $clog2(SECTORS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FMT, S_REQ, S_XFER} state_t;
  state_t state;

  logic [7:0]         ram_lo [NW];
  logic [7:0]         ram_hi [NW];
  logic [SECTORS-1:0] dirty;
  logic [SW-1:0]      sec, csec, s_first;
  logic [WA-1:0]      fmt_addr, ca_w, b_addr, pb_addr;
  logic [15:0]        pb_data;
  logic               pb_we, op_load, op_auto;
  logic               ld_q, sv_q, fm_q, dl_q, ack_q, ack_ok;
  logic               go_load, go_save, go_auto, go_fmt, ack_rise, ack_fall, fmt_last;
  logic [SW:0]        auto_first, nxt;

  // Lowest set bit of m strictly above 'from'; MSB flags whether one exists.
  function automatic logic [SW:0] find_sec(input logic [SECTORS-1:0] m, input int from);
    logic [SW:0] r;
    r = '0;
    for (int i = SECTORS-1; i >= 0; i--)
      if (m[i] && i > from) r = {1'b1, SW'(i)};
    return r;
  endfunction

  assign ca_w     = core_addr[AW-1:1];
  assign csec     = SW'(core_addr >> 9);
  assign b_addr   = WA'({sd_lba, sd_buff_addr});
  assign fmt_last = (fmt_addr == WA'(NW-1));
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;

  assign go_load = bk_ena & ((load_req & ~ld_q) | (dl_q & ~downloading & img_size_nz));
  assign go_save = bk_ena & save_req & ~sv_q;
  assign go_auto = bk_ena & osd_status & autosave_en & (|dirty);
  assign go_fmt  = format_req & ~fm_q;

  assign auto_first = find_sec(dirty, -1);
  assign s_first    = (go_load | go_save) ? '0 : auto_first[SW-1:0];
  assign nxt        = find_sec(op_auto ? dirty : {SECTORS{1'b1}}, int'(sec));

  assign pending = (|dirty) & bk_ena & ~osd_status;

  // Port B is shared by the format walker and host writes; ack is trusted only after seen low.
  assign pb_we   = (state == S_FMT) | (sd_buff_wr & sd_ack & ack_ok);
  assign pb_addr = (state == S_FMT) ? fmt_addr : b_addr;
  assign pb_data = (state != S_FMT)          ? sd_buff_dout :
                   (fmt_addr[WA-1:2] == '0)  ? FMT_HDR[{fmt_addr[1:0], 4'b0000} +: 16] : 16'h0000;

  always_ff @(posedge clk_sys) begin
    if (core_we & ~core_addr[0] & ~(pb_we & (pb_addr == ca_w))) ram_lo[ca_w] <= core_din;
    if (core_we &  core_addr[0] & ~(pb_we & (pb_addr == ca_w))) ram_hi[ca_w] <= core_din;
    if (pb_we) begin
      ram_lo[pb_addr] <= pb_data[7:0];
      ram_hi[pb_addr] <= pb_data[15:8];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      core_dout   <= '0;
      sd_buff_din <= '0;
    end else begin
      core_dout   <= core_addr[0] ? ram_hi[ca_w] : ram_lo[ca_w];
      sd_buff_din <= {ram_hi[b_addr], ram_lo[b_addr]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_lba   <= '0;
      busy     <= 1'b0;
      loading  <= 1'b0;
      bk_ena   <= 1'b0;
      dirty    <= '0;
      sec      <= '0;
      op_load  <= 1'b0;
      op_auto  <= 1'b0;
      fmt_addr <= '0;
      ld_q     <= 1'b0;
      sv_q     <= 1'b0;
      fm_q     <= 1'b0;
      dl_q     <= 1'b0;
      ack_q    <= 1'b1;
      ack_ok   <= 1'b0;
    end else begin
      ld_q  <= load_req;
      sv_q  <= save_req;
      fm_q  <= format_req;
      dl_q  <= downloading;
      ack_q <= sd_ack;
      if (!sd_ack) ack_ok <= 1'b1;

      if (downloading & ~dl_q) bk_ena <= 1'b0;
      if (downloading & img_mounted & ~img_readonly) bk_ena <= 1'b1;

      case (state)
        S_IDLE: begin
          if (go_load | go_save | go_auto) begin
            state   <= S_REQ;
            busy    <= 1'b1;
            op_load <= go_load;
            op_auto <= ~go_load & ~go_save;
            loading <= go_load;
            sd_rd   <= go_load;
            sd_wr   <= ~go_load;
            sec     <= s_first;
            sd_lba  <= 32'(s_first);
          end else if (go_fmt) begin
            state    <= S_FMT;
            busy     <= 1'b1;
            fmt_addr <= '0;
          end
        end
        S_FMT: begin
          fmt_addr <= fmt_addr + 1'b1;
          if (fmt_last) begin
            dirty <= '1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (ack_fall) begin
            if (!op_load) dirty[sec] <= 1'b0;
            if (nxt[SW]) begin
              sec    <= nxt[SW-1:0];
              sd_lba <= 32'(nxt[SW-1:0]);
              sd_rd  <= op_load;
              sd_wr  <= ~op_load;
              state  <= S_REQ;
            end else begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              loading <= 1'b0;
              if (op_load) dirty <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A core write in the same cycle as a save's ack fall keeps the sector dirty.
      if (core_we) dirty[csec] <= 1'b1;
    end
  end
endmodule
